// File: rtl/famicom_bus_master_pkg.sv
// Famicom cart-edge bus master: shared types and parameter checks.
// PPU sequencer state encoding and M2/PPU divider legality.
package famicom_bus_master_pkg;

  typedef enum logic [1:0] {
    PPU_IDLE   = 2'd0,
    PPU_SETUP  = 2'd1,
    PPU_STROBE = 2'd2,
    PPU_HOLD   = 2'd3
  } ppu_state_e;

  localparam int M2_DIV_DEF  = 12;
  localparam int PPU_DIV_DEF = 4;

  function automatic bit m2_div_ok(input int d);
    return (d >= 4) && (d % 2 == 0);
  endfunction

  function automatic bit ppu_div_ok(input int d);
    return d >= 3;
  endfunction

endpackage

// File: rtl/famicom_ppu_bus_seq.sv
// PPU-side access sequencer: SETUP, STROBE, HOLD around /RD or /WR.
// Runs independently of the CPU m2 timebase.
module famicom_ppu_bus_seq
  import famicom_bus_master_pkg::*;
#(
  parameter int PPU_DIV = PPU_DIV_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [13:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rd_no,
  output logic        wr_no,
  output logic [13:0] addr_o,
  output logic [7:0]  data_o,
  output logic        data_oe_o,
  input  logic [7:0]  data_i
);

  localparam int CW = $clog2(PPU_DIV);
  localparam logic [CW-1:0] SLEN = CW'(PPU_DIV - 3);

  if (!ppu_div_ok(PPU_DIV)) begin : g_chk
    $error("PPU_DIV must be >= 3");
  end

  ppu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        oe_q, oe_d;
  logic        rsp_q, rsp_d;
  logic [7:0]  rdata_q;
  logic        accept, cap;

  assign accept = (state_q == PPU_IDLE) & req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= PPU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PPU_IDLE:   if (req_valid_i) state_d = PPU_SETUP;
      PPU_SETUP:  state_d = PPU_STROBE;
      PPU_STROBE: if (cnt_q == '0) state_d = PPU_HOLD;
      PPU_HOLD:   state_d = PPU_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    write_d = accept ? req_write_i : write_q;
    addr_d  = accept ? req_addr_i  : addr_q;
    wdata_d = accept ? req_wdata_i : wdata_q;
    if (state_q == PPU_SETUP)
      cnt_d = SLEN;
    else if (state_q == PPU_STROBE && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    rd_d  = ~((state_d == PPU_STROBE) & ~write_d);
    wr_d  = ~((state_d == PPU_STROBE) &  write_d);
    oe_d  = (state_d == PPU_STROBE) & write_d;
    rsp_d = (state_q == PPU_HOLD);
    cap   = (state_q == PPU_STROBE) & (cnt_q == '0) & ~write_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      rsp_q   <= rsp_d;
      if (cap) rdata_q <= data_i;
    end
  end

  assign req_ready_o = (state_q == PPU_IDLE);
  assign rsp_valid_o = rsp_q;
  assign rsp_rdata_o = rdata_q;
  assign rd_no       = rd_q;
  assign wr_no       = wr_q;
  assign addr_o      = addr_q;
  assign data_o      = wdata_q;
  assign data_oe_o   = oe_q;

endmodule

// File: rtl/famicom_bus_master.sv
// Famicom cartridge-edge initiator: free-running m2 CPU cycles,
// independent PPU sequencer and /IRQ synchronizer.
module famicom_bus_master
  import famicom_bus_master_pkg::*;
#(
  parameter int M2_DIV  = M2_DIV_DEF,
  parameter int PPU_DIV = PPU_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_req_valid,
  output logic        ppu_req_ready,
  input  logic        ppu_req_write,
  input  logic [13:0] ppu_req_addr,
  input  logic [7:0]  ppu_req_wdata,
  output logic        ppu_rsp_valid,
  output logic [7:0]  ppu_rsp_rdata,
  output logic        ppu_rd,
  output logic        ppu_wr,
  output logic [13:0] ppu_addr,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_oe,
  input  logic [7:0]  ppu_data_in,
  input  logic        irq_n,
  output logic        irq_level
);

  localparam int PW = $clog2(M2_DIV);
  localparam logic [PW-1:0] LAST   = PW'(M2_DIV - 1);
  localparam logic [PW-1:0] HALF_P = PW'(M2_DIV / 2);

  if (!m2_div_ok(M2_DIV)) begin : g_chk
    $error("M2_DIV must be even and >= 4");
  end

  logic [PW-1:0] phase_q, phase_d;
  logic          wrap, accept, launch, m2_d;
  logic          pend_q, pend_d;
  logic          pwr_q;
  logic [15:0]   paddr_q;
  logic [7:0]    pdata_q;
  logic          act_q, act_d;
  logic          wr_q, wr_d;
  logic          a15_q, a15_d;
  logic [14:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          m2_q, romsel_q, rw_q, oe_q;
  logic          rsp_q;
  logic [7:0]    rdata_q;
  logic          irq_s1_q, irq_s2_q, irq_lvl_q;

  assign wrap = (phase_q == LAST);

  always_comb begin
    phase_d = wrap ? '0 : phase_q + 1'b1;
    m2_d    = (phase_d >= HALF_P);
    accept  = req_valid & ~pend_q;
    launch  = wrap & pend_q;
    pend_d  = accept | (pend_q & ~launch);
    // a period with nothing pending becomes an idle bus period
    act_d   = wrap ? pend_q : act_q;
    wr_d    = launch ? pwr_q          : wr_q;
    a15_d   = launch ? paddr_q[15]    : a15_q;
    addr_d  = launch ? paddr_q[14:0]  : addr_q;
    wdata_d = launch ? pdata_q        : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      pend_q   <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      act_q    <= 1'b0;
      wr_q     <= 1'b0;
      a15_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      m2_q     <= 1'b0;
      romsel_q <= 1'b1;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      rsp_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      if (accept) begin
        pwr_q   <= req_write;
        paddr_q <= req_addr;
        pdata_q <= req_wdata;
      end
      act_q    <= act_d;
      wr_q     <= wr_d;
      a15_q    <= a15_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      m2_q     <= m2_d;
      romsel_q <= ~(act_d & a15_d & m2_d);
      rw_q     <= ~(act_d & wr_d);
      oe_q     <= act_d & wr_d & m2_d;
      rsp_q    <= wrap & act_q;
      if (wrap & act_q & ~wr_q) rdata_q <= cpu_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q  <= 1'b1;
      irq_s2_q  <= 1'b1;
      irq_lvl_q <= 1'b0;
    end else begin
      irq_s1_q  <= irq_n;
      irq_s2_q  <= irq_s1_q;
      irq_lvl_q <= ~irq_s2_q;
    end
  end

  assign req_ready    = ~pend_q;
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = wdata_q;
  assign cpu_data_oe  = oe_q;
  assign irq_level    = irq_lvl_q;

  famicom_ppu_bus_seq #(
    .PPU_DIV (PPU_DIV)
  ) u_ppu (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (ppu_req_valid),
    .req_ready_o (ppu_req_ready),
    .req_write_i (ppu_req_write),
    .req_addr_i  (ppu_req_addr),
    .req_wdata_i (ppu_req_wdata),
    .rsp_valid_o (ppu_rsp_valid),
    .rsp_rdata_o (ppu_rsp_rdata),
    .rd_no       (ppu_rd),
    .wr_no       (ppu_wr),
    .addr_o      (ppu_addr),
    .data_o      (ppu_data_out),
    .data_oe_o   (ppu_data_oe),
    .data_i      (ppu_data_in)
  );

endmodule

// File: tb/tb_famicom_bus_master.sv
// Self-checking bench for famicom_bus_master against a phase-based
// reference model of the cart-edge timing.
module tb_famicom_bus_master;

  localparam int M2   = 12;
  localparam int HALF = M2 / 2;
  localparam int PD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2, romsel, cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in = '0;
  logic        ppu_req_valid = 1'b0;
  logic        ppu_req_ready;
  logic        ppu_req_write = 1'b0;
  logic [13:0] ppu_req_addr = '0;
  logic [7:0]  ppu_req_wdata = '0;
  logic        ppu_rsp_valid;
  logic [7:0]  ppu_rsp_rdata;
  logic        ppu_rd, ppu_wr;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_oe;
  logic [7:0]  ppu_data_in = '0;
  logic        irq_n = 1'b1;
  logic        irq_level;

  int vectors = 0;
  int errors  = 0;
  int tick;

  always #5 clk = ~clk;

  // posedges seen since reset release; phase of the m2 period is tick % M2
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;

  famicom_bus_master #(.M2_DIV(M2), .PPU_DIV(PD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .m2            (m2),
    .romsel        (romsel),
    .cpu_rw        (cpu_rw),
    .cpu_addr      (cpu_addr),
    .cpu_data_out  (cpu_data_out),
    .cpu_data_oe   (cpu_data_oe),
    .cpu_data_in   (cpu_data_in),
    .ppu_req_valid (ppu_req_valid),
    .ppu_req_ready (ppu_req_ready),
    .ppu_req_write (ppu_req_write),
    .ppu_req_addr  (ppu_req_addr),
    .ppu_req_wdata (ppu_req_wdata),
    .ppu_rsp_valid (ppu_rsp_valid),
    .ppu_rsp_rdata (ppu_rsp_rdata),
    .ppu_rd        (ppu_rd),
    .ppu_wr        (ppu_wr),
    .ppu_addr      (ppu_addr),
    .ppu_data_out  (ppu_data_out),
    .ppu_data_oe   (ppu_data_oe),
    .ppu_data_in   (ppu_data_in),
    .irq_n         (irq_n),
    .irq_level     (irq_level)
  );

  task automatic cpu_req(input bit w, input logic [15:0] a,
                         input logic [7:0] d, output int t);
    bit done = 1'b0;
    t = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      if (req_ready === 1'b1) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = tick;
        done = 1'b1;
      end
    end
    if (!done) begin
      req_valid = 1'b0;
      vectors++; errors++;
      $display("FAIL cpu_accept_timeout got ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m2, romsel, cpu_rw, cpu_data_oe, rsp_valid, req_ready} !== 6'b011001) begin
      errors++;
      $display("FAIL reset_cpu_ctl got %b want 011001",
               {m2, romsel, cpu_rw, cpu_data_oe, rsp_valid, req_ready});
    end
    vectors++;
    if (cpu_addr !== 15'h0 || rsp_rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_cpu_data got addr=%h rdata=%h want 0 0", cpu_addr, rsp_rdata);
    end
    vectors++;
    if ({ppu_rd, ppu_wr, ppu_data_oe, ppu_rsp_valid, ppu_req_ready} !== 5'b11001
        || ppu_addr !== 14'h0) begin
      errors++;
      $display("FAIL reset_ppu got %b addr=%h want 11001 0",
               {ppu_rd, ppu_wr, ppu_data_oe, ppu_rsp_valid, ppu_req_ready}, ppu_addr);
    end
    vectors++;
    if (irq_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b want 0", irq_level);
    end
    rst_n = 1'b1;
  endtask

  // One CPU transaction checked clock by clock against the phase model
  task automatic test_cpu_xfer(input bit w, input logic [15:0] a,
                               input logic [7:0] d, input logic [7:0] c);
    int t, L, ph, pulses;
    logic exp_rom, exp_oe, exp_m2;
    pulses = 0;
    cpu_data_in = c;
    cpu_req(w, a, d, t);
    if (t < 0) return;
    L = (t / M2 + 1) * M2;
    vectors++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept got %b want 0", req_ready);
    end
    while (tick < L + M2) begin
      @(negedge clk);
      ph = tick % M2;
      exp_m2 = (ph >= HALF);
      if (tick >= L && tick < L + M2) begin
        exp_rom = !(a[15] && exp_m2);
        exp_oe  = w && exp_m2;
        vectors++;
        if (romsel !== exp_rom || cpu_rw !== !w || cpu_data_oe !== exp_oe ||
            cpu_addr !== a[14:0] || m2 !== exp_m2 ||
            (exp_oe && cpu_data_out !== d)) begin
          errors++;
          $display("FAIL cpu_cycle ph=%0d got rom=%b rw=%b oe=%b a=%h m2=%b d=%h want %b %b %b %h %b %h",
                   ph, romsel, cpu_rw, cpu_data_oe, cpu_addr, m2, cpu_data_out,
                   exp_rom, !w, exp_oe, a[14:0], exp_m2, d);
        end
      end else if (tick < L) begin
        vectors++;
        if (romsel !== 1'b1 || cpu_rw !== 1'b1 || cpu_data_oe !== 1'b0 || m2 !== exp_m2) begin
          errors++;
          $display("FAIL cpu_idle ph=%0d got rom=%b rw=%b oe=%b m2=%b want 1 1 0 %b",
                   ph, romsel, cpu_rw, cpu_data_oe, m2, exp_m2);
        end
      end
      if (rsp_valid === 1'b1) begin
        pulses++;
        vectors++;
        if (tick != L + M2 || (!w && rsp_rdata !== c)) begin
          errors++;
          $display("FAIL cpu_rsp got tick=%0d rdata=%h want tick=%0d rdata=%h",
                   tick - L, rsp_rdata, M2, c);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL cpu_rsp_count got %0d want 1", pulses);
    end
    if (!w) begin
      cpu_data_in = ~c;
      @(negedge clk);
      vectors++;
      if (rsp_rdata !== c || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdata_hold got %h/%b want %h/0", rsp_rdata, rsp_valid, c);
      end
    end
  endtask

  task automatic test_cpu_write();
    test_cpu_xfer(1'b1, 16'h8000, 8'h5A, 8'h00);
  endtask

  task automatic test_cpu_read();
    test_cpu_xfer(1'b0, 16'h6000, 8'h00, 8'hC3);
  endtask

  task automatic test_random_cpu();
    for (int i = 0; i < 12; i++)
      test_cpu_xfer(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_back_to_back();
    localparam int N = 5;
    logic [15:0] a [N];
    bit          w [N];
    int          t [N];
    logic [15:0] obs [int];
    int L0, Lm, L;
    for (int i = 0; i < N; i++) begin
      a[i] = 16'($urandom);
      w[i] = 1'($urandom);
    end
    fork
      begin
        for (int i = 0; i < N; i++) begin
          cpu_req(w[i], a[i], 8'($urandom), t[i]);
          vectors++;
          if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_pending got %b want 0", req_ready);
          end
        end
      end
      begin
        for (int k = 0; k < (N + 3) * M2; k++) begin
          @(negedge clk);
          if (tick % M2 == 0) obs[tick] = {cpu_rw, cpu_addr};
        end
      end
    join
    L0 = (t[0] / M2 + 1) * M2;
    for (int i = 0; i < N; i++) begin
      L  = L0 + i * M2;
      Lm = (t[i] / M2 + 1) * M2;
      vectors++;
      if (t[i] < 0 || Lm != L || !obs.exists(L) || obs[L] !== {!w[i], a[i][14:0]}) begin
        errors++;
        $display("FAIL b2b_launch i=%0d got launch=%0d bus=%h want launch=%0d bus=%h",
                 i, Lm, obs.exists(L) ? obs[L] : 16'hxxxx, L, {!w[i], a[i][14:0]});
      end
    end
    repeat (2 * M2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t, L, bad;
    bit guard;
    bad = 0;
    cpu_req(1'b1, 16'h8000, 8'hA5, t);
    if (t < 0) return;
    L = (t / M2 + 1) * M2;
    guard = 1'b0;
    for (int i = 0; i < 40 && !guard; i++) begin
      @(negedge clk);
      if (tick == L + 8) guard = 1'b1;
    end
    vectors++;
    if (!guard || romsel !== 1'b0 || cpu_data_oe !== 1'b1 || cpu_rw !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre got rom=%b oe=%b rw=%b want 0 1 0", romsel, cpu_data_oe, cpu_rw);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({romsel, cpu_data_oe, cpu_rw, m2, rsp_valid, req_ready} !== 6'b101001 ||
        cpu_addr !== 15'h0) begin
      errors++;
      $display("FAIL midrst_abort got %b addr=%h want 101001 0",
               {romsel, cpu_data_oe, cpu_rw, m2, rsp_valid, req_ready}, cpu_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || m2 !== ((tick % M2) >= HALF) || romsel !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_after got %0d bad clks want 0", bad);
    end
  endtask

  task automatic test_ppu(input bit w, input logic [13:0] a,
                          input logic [7:0] d, input logic [7:0] c);
    bit ok = 1'b0;
    bit strobe;
    logic exp_rd, exp_wr, exp_oe, exp_last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ppu_req_ready === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL ppu_ready_timeout got 0 want 1");
      return;
    end
    ppu_req_write = w; ppu_req_addr = a; ppu_req_wdata = d; ppu_req_valid = 1'b1;
    @(posedge clk); #1;
    ppu_req_valid = 1'b0;
    for (int k = 0; k <= PD; k++) begin
      @(negedge clk);
      // only the data present during the final strobe clock may be captured
      ppu_data_in = (k == PD - 2) ? c : ~c;
      strobe   = (k >= 1 && k <= PD - 2);
      exp_rd   = !(strobe && !w);
      exp_wr   = !(strobe && w);
      exp_oe   = strobe && w;
      exp_last = (k == PD);
      vectors++;
      if (ppu_rd !== exp_rd || ppu_wr !== exp_wr || ppu_data_oe !== exp_oe ||
          ppu_rsp_valid !== exp_last || ppu_req_ready !== exp_last ||
          ppu_addr !== a || (exp_oe && ppu_data_out !== d) ||
          (exp_last && !w && ppu_rsp_rdata !== c)) begin
        errors++;
        $display("FAIL ppu_seq k=%0d got rd=%b wr=%b oe=%b rsp=%b rdy=%b a=%h do=%h rd=%h want %b %b %b %b %b %h %h %h",
                 k, ppu_rd, ppu_wr, ppu_data_oe, ppu_rsp_valid, ppu_req_ready,
                 ppu_addr, ppu_data_out, ppu_rsp_rdata,
                 exp_rd, exp_wr, exp_oe, exp_last, exp_last, a, d, c);
      end
    end
    @(negedge clk);
    vectors++;
    if (ppu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ppu_rsp_pulse got %b want 0", ppu_rsp_valid);
    end
  endtask

  task automatic test_ppu_dir();
    test_ppu(1'b0, 14'h1FF0, 8'h00, 8'h77);
    for (int i = 0; i < 6; i++)
      test_ppu(1'($urandom), 14'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_simultaneous();
    fork
      test_cpu_xfer(1'b0, 16'hC123, 8'h00, 8'h3C);
      test_ppu(1'b1, 14'h2007, 8'h99, 8'h00);
    join
  endtask

  task automatic test_idle_irq();
    int rises, rom_bad, tgl;
    logic prev, exp_lvl;
    bit sync = 1'b0;
    rises = 0; rom_bad = 0; tgl = -100; exp_lvl = 1'b0;
    for (int i = 0; i < 2 * M2 && !sync; i++) begin
      @(negedge clk);
      if (tick % M2 == 0) sync = 1'b1;
    end
    prev = m2;
    for (int i = 0; i < 100 * M2; i++) begin
      @(negedge clk);
      if (m2 === 1'b1 && prev === 1'b0) rises++;
      prev = m2;
      if (romsel !== 1'b1) rom_bad++;
      if (i == tgl + 2) begin
        vectors++;
        if (irq_level !== !exp_lvl) begin
          errors++;
          $display("FAIL irq_lag_early got %b want %b", irq_level, !exp_lvl);
        end
      end
      if (i == tgl + 3) begin
        vectors++;
        if (irq_level !== exp_lvl) begin
          errors++;
          $display("FAIL irq_lag_late got %b want %b", irq_level, exp_lvl);
        end
      end
      if (i % 50 == 10) begin
        irq_n = ~irq_n;
        exp_lvl = ~irq_n;
        tgl = i;
      end
    end
    vectors++;
    if (rises != 100 || rom_bad != 0) begin
      errors++;
      $display("FAIL idle_m2 got rises=%0d rom_bad=%0d want 100 0", rises, rom_bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_random_cpu();
    test_back_to_back();
    test_reset_mid();
    test_ppu_dir();
    test_simultaneous();
    test_idle_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
